// File: rtl/vga_pixel_ce_gen_pkg.sv
// Shared types and rate constants for the NCO pixel clock-enable generator.
// Increments assume ACC_W=32 and a 50 MHz reference clock.
package vga_clk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    LOCKED  = 2'd2,
    PENDING = 2'd3
  } state_t;

  localparam logic [31:0] INC_640x480 = 32'd2162571353;  // 25.175644 MHz
  localparam logic [31:0] INC_800x600 = 32'd3435973837;  // 40.000 MHz

endpackage

// File: rtl/vga_pixel_ce_gen_if.sv
// Rate configuration port of the pixel clock-enable generator.
interface vga_pixel_ce_gen_if #(
  parameter int unsigned ACC_W = 32
);
  // cfg_inc transfers on a refclk edge where cfg_valid && cfg_ready. The master
  // holds cfg_valid/cfg_inc stable until that edge; cfg_ready never depends on cfg_valid.
  logic             cfg_valid;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_inc, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_inc, output cfg_ready);
endinterface

// File: rtl/vga_pixel_ce_gen_lock_counter.sv
// Counts pixel enables after a rate change and raises locked once the count
// reaches LOCK_CYCLES; saturates there.
module vga_lock_counter #(
  parameter  int unsigned LOCK_CYCLES = 1024,
  localparam int unsigned CNT_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic             en,
  output logic [CNT_W-1:0] settle_cnt,
  output logic             locked,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  // hit marks the tick that completes the settle window
  assign hit = en && !clr && tick && (settle_cnt == CNT_LAST);

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else if (clr) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else if (!en) begin
      locked <= 1'b0;
    end else if (tick) begin
      if (settle_cnt != CNT_MAX) settle_cnt <= settle_cnt + 1'b1;
      if (settle_cnt == CNT_LAST) locked <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_ce_gen.sv
// Phase-accumulator pixel clock-enable with runtime rate reprogramming; rate
// switches land on an accumulator wrap so the enable stream never glitches.
module vga_pixel_ce_gen
  import vga_clk_pkg::*;
#(
  parameter  int unsigned      ACC_W       = 32,
  parameter  logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_640x480),
  parameter  int unsigned      LOCK_CYCLES = 1024,
  localparam int unsigned      CNT_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 en,
  vga_pixel_ce_gen_if.slave    cfg,
  output logic                 pix_ce,
  output logic                 locked,
  output logic [ACC_W-1:0]     active_inc,
  output state_t               state,
  output logic [CNT_W-1:0]     settle_cnt
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] pend_inc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] apply_inc;
  logic             run, carry, accept;
  logic             apply_now, apply_wrap, clr, tick, hit;

  assign run   = en && (active_inc != '0);
  assign sum   = {1'b0, acc} + {1'b0, active_inc};
  assign carry = run && sum[ACC_W];

  assign cfg.cfg_ready = (state != PENDING);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  // A stopped accumulator has no wrap to wait for, so the new rate goes in at once.
  assign apply_now  = accept && (active_inc == '0);
  assign apply_wrap = !accept && (state == PENDING) && carry;
  assign apply_inc  = apply_now ? cfg.cfg_inc : pend_inc;

  assign clr  = apply_now || apply_wrap || ((state == LOCKED) && !en);
  assign tick = pix_ce && (state == SETTLE);

  vga_lock_counter #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock (
    .refclk     (refclk),
    .rst        (rst),
    .clr        (clr),
    .tick       (tick),
    .en         (en),
    .settle_cnt (settle_cnt),
    .locked     (locked),
    .hit        (hit)
  );

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      active_inc <= INC_DEFAULT;
      pend_inc   <= '0;
      pix_ce     <= 1'b0;
      state      <= SETTLE;
    end else begin
      pix_ce <= carry;
      if (run) acc <= sum[ACC_W-1:0];
      if (accept) pend_inc <= cfg.cfg_inc;

      // acc is deliberately left alone on apply to keep phase continuity
      if (apply_now || apply_wrap) begin
        active_inc <= apply_inc;
        state      <= (apply_inc == '0) ? IDLE : SETTLE;
      end else if (accept) begin
        state <= PENDING;
      end else begin
        case (state)
          SETTLE:  if (hit) state <= LOCKED;
          LOCKED:  if (!en) state <= SETTLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_ce_gen.sv
// Directed bench for vga_pixel_ce_gen at ACC_W=8, INC_DEFAULT=128, LOCK_CYCLES=4.
module tb_vga_pixel_ce_gen;
  import vga_clk_pkg::*;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned LOCK  = 4;

  logic             refclk;
  logic             rst;
  logic             en;
  logic             pix_ce;
  logic             locked;
  logic [ACC_W-1:0] active_inc;
  state_t           state;
  logic [2:0]       settle_cnt;

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;

  vga_pixel_ce_gen_if #(.ACC_W(ACC_W)) cfg_if ();

  vga_pixel_ce_gen #(
    .ACC_W       (ACC_W),
    .INC_DEFAULT (8'd128),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .en         (en),
    .cfg        (cfg_if),
    .pix_ce     (pix_ce),
    .locked     (locked),
    .active_inc (active_inc),
    .state      (state),
    .settle_cnt (settle_cnt)
  );

  // clock / reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // driver
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst              = 1'b0;
    en               = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_inc   = '0;
    repeat (2) @(posedge refclk);
    #1;

    // reset values
    check("rst_pix", pix_ce, 0);
    check("rst_locked", locked, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    check("rst_inc", active_inc, 128);
    check("rst_state", state, SETTLE);
    rst = 1'b1;

    // 1: default rate, pulse every 2nd cycle, lock after 4th pulse
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_pix", pix_ce, (k % 2 == 0));
      check("t1_unlocked", locked, 0);
    end
    step();
    check("t1_locked", locked, 1);
    check("t1_state", state, LOCKED);
    check("t1_cnt", settle_cnt, 4);

    // 2: switch to 64 while locked, apply waits for the next wrap
    step();
    check("t2_pre_pix", pix_ce, 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd64;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t2_ready_low", cfg_if.cfg_ready, 0);
    check("t2_pending", state, PENDING);
    check("t2_hold_lock", locked, 1);
    check("t2_old_inc", active_inc, 128);
    step();
    check("t2_apply_inc", active_inc, 64);
    check("t2_apply_unlock", locked, 0);
    check("t2_apply_pix", pix_ce, 1);
    check("t2_ready_high", cfg_if.cfg_ready, 1);
    check("t2_settle", state, SETTLE);
    for (int k = 13; k <= 24; k++) begin
      step();
      check("t2_pix", pix_ce, (k % 4 == 0));
      check("t2_unlocked", locked, 0);
    end
    step();
    check("t2_relock", locked, 1);
    check("t2_state", state, LOCKED);

    // 3: stop via inc=0, then restart at 255
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd0;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t3_pending", state, PENDING);
    check("t3_ready_low", cfg_if.cfg_ready, 0);
    step();
    check("t3_wait_inc", active_inc, 64);
    step();
    check("t3_idle_inc", active_inc, 0);
    check("t3_idle", state, IDLE);
    check("t3_unlocked", locked, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_idle_pix", pix_ce, 0);
      check("t3_idle_lock", locked, 0);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd255;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t3_inc255", active_inc, 255);
    check("t3_settle", state, SETTLE);
    step();
    check("t3_first_pix", pix_ce, 0);
    for (int k = 2; k <= 257; k++) begin
      step();
      if (pix_ce === 1'b1) npulse++;
      if (k <= 5) check("t3_pix_run", pix_ce, 1);
      if (k == 5) check("t3_not_yet", locked, 0);
      if (k == 6) check("t3_locked", locked, 1);
      if (k == 257) check("t3_gap", pix_ce, 0);
    end
    check("t3_pulses", npulse, 255);

    // 4: config offered on a carry cycle; that carry must not apply it
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd128;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t4_carry_pix", pix_ce, 1);
    check("t4_not_applied", active_inc, 255);
    check("t4_pending", state, PENDING);
    step();
    check("t4_applied", active_inc, 128);
    check("t4_settle", state, SETTLE);
    check("t4_unlocked", locked, 0);
    check("t4_pix", pix_ce, 1);

    // 5: relock, freeze for 10 cycles, resume from the frozen phase
    for (int k = 1; k <= 6; k++) begin
      step();
      check("t5_pix", pix_ce, (k % 2 == 1));
      check("t5_lock", locked, (k == 6));
    end
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t5_off_pix", pix_ce, 0);
      check("t5_off_lock", locked, 0);
      if (k == 1) check("t5_off_state", state, SETTLE);
    end
    check("t5_off_cnt", settle_cnt, 0);
    en = 1'b1;
    for (int k = 17; k <= 24; k++) begin
      step();
      check("t5_resume_pix", pix_ce, (k % 2 == 1));
      check("t5_resume_lock", locked, (k == 24));
    end

    // 6: asynchronous reset while a config is pending
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_inc   = 8'd64;
    step();
    cfg_if.cfg_valid = 1'b0;
    check("t6_pending", state, PENDING);
    check("t6_pix", pix_ce, 1);
    check("t6_locked", locked, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_pix", pix_ce, 0);
    check("t6_rst_lock", locked, 0);
    check("t6_rst_ready", cfg_if.cfg_ready, 1);
    check("t6_rst_inc", active_inc, 128);
    check("t6_rst_state", state, SETTLE);
    check("t6_rst_cnt", settle_cnt, 0);
    @(posedge refclk);
    #1;
    rst = 1'b1;
    step();
    check("t6_e1_pix", pix_ce, 0);
    step();
    check("t6_e2_pix", pix_ce, 1);
    step();
    check("t6_inc_kept", active_inc, 128);
    check("t6_state_kept", state, SETTLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
